// File: rtl/grom_io_ctrl_if.sv
// grom8 CPU-side I/O bus bundle.
// Groups address, write data, read data and the cycle qualifiers.
//   addr     : CPU address (low bits select the I/O register)
//   data_in  : CPU write data
//   data_out : registered read data returned to the CPU
//   we       : 1 = write, 0 = read
//   ioreq    : qualifies the cycle as an I/O access
interface grom_io_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  we;
    logic                  ioreq;

    modport master (
        output addr,
        output data_in,
        output we,
        output ioreq,
        input  data_out
    );

    modport slave (
        input  addr,
        input  data_in,
        input  we,
        input  ioreq,
        output data_out
    );
endinterface

// File: rtl/grom_io_ctrl.sv
// grom8 I/O controller: output registers, synchronised inputs with
// sticky rising-edge capture, and a time-multiplexed display scanner.
//
// Ports:
//   clk, reset  : clock and asynchronous active-high reset
//   bus         : CPU I/O bus (slave side), see grom_io_ctrl_if
//   port_in     : asynchronous inputs, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   port_out    : output registers, packed like port_in
//   out_strobe  : one-cycle pulse after an output register write
//   scan_sel    : one-hot active scan slot
//   scan_data   : output register of the active scan slot
//
// Address map (full compare, upper bits must be zero):
//   0 .. N-1     : OUT[a] on write, SYNC_IN[a] on read
//   N .. 2N-1    : CAP[a-N], read-to-clear and write-1-to-clear
//   anything else: writes ignored, reads return 0
module grom_io_ctrl #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    NUM_PORTS   = 4,
    parameter int                    SCAN_DIV    = 1000,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    grom_io_ctrl_if.slave                   bus,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_in,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] port_out,
    output logic [NUM_PORTS-1:0]            out_strobe,
    output logic [NUM_PORTS-1:0]            scan_sel,
    output logic [DATA_WIDTH-1:0]           scan_data
);
    localparam int DW = DATA_WIDTH;
    localparam int VW = NUM_PORTS * DATA_WIDTH;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SLOT_MAX  = SW'(NUM_PORTS - 1);

    // Register state
    logic [VW-1:0]        out_q, out_d;
    logic [NUM_PORTS-1:0] strobe_q, strobe_d;
    logic [DW-1:0]        dout_q, dout_d;
    logic [VW-1:0]        sync1_q, sync1_d;
    logic [VW-1:0]        sync2_q, sync2_d;
    logic [VW-1:0]        prev_q, prev_d;
    logic [VW-1:0]        cap_q, cap_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [SW-1:0]        slot_q, slot_d;

    // Decode
    logic                 wr;
    logic                 rd;
    logic [NUM_PORTS-1:0] out_hit;
    logic [NUM_PORTS-1:0] cap_hit;
    logic [VW-1:0]        rise;
    logic [VW-1:0]        clr;
    logic                 wrap;

    assign wr = bus.ioreq & bus.we;
    assign rd = bus.ioreq & ~bus.we;

    always_comb begin
        out_hit = '0;
        cap_hit = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            out_hit[i] = (bus.addr == ADDR_WIDTH'(i));
            cap_hit[i] = (bus.addr == ADDR_WIDTH'(NUM_PORTS + i));
        end
    end

    // Bus access, input path and edge capture
    always_comb begin
        out_d    = out_q;
        strobe_d = '0;
        dout_d   = dout_q;
        sync1_d  = port_in;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        rise     = sync2_q & ~prev_q;
        clr      = '0;

        // A read of an unmapped address returns zero.
        if (rd) begin
            dout_d = '0;
        end

        for (int i = 0; i < NUM_PORTS; i++) begin
            if (wr && out_hit[i]) begin
                out_d[i*DW +: DW] = bus.data_in;
                strobe_d[i]       = 1'b1;
            end
            if (rd && out_hit[i]) begin
                dout_d = sync2_q[i*DW +: DW];
            end
            if (cap_hit[i]) begin
                if (wr) begin
                    clr[i*DW +: DW] = bus.data_in;
                end
                if (rd) begin
                    clr[i*DW +: DW] = '1;
                    dout_d          = cap_q[i*DW +: DW];
                end
            end
        end

        // Set is applied after clear so a coincident edge survives.
        cap_d = (cap_q & ~clr) | rise;
    end

    // Scanner: prescaler and slot index
    always_comb begin
        wrap    = (presc_q == PRESC_MAX);
        presc_d = wrap ? '0 : presc_q + PW'(1);
        slot_d  = slot_q;
        if (wrap) begin
            slot_d = (slot_q == SLOT_MAX) ? '0 : slot_q + SW'(1);
        end
    end

    always_comb begin
        scan_sel  = '0;
        scan_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (slot_q == SW'(i)) begin
                scan_sel[i] = 1'b1;
                scan_data   = out_q[i*DW +: DW];
            end
        end
    end

    assign port_out     = out_q;
    assign out_strobe   = strobe_q;
    assign bus.data_out = dout_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q    <= {NUM_PORTS{RESET_VALUE}};
            strobe_q <= '0;
            dout_q   <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            cap_q    <= '0;
            presc_q  <= '0;
            slot_q   <= '0;
        end else begin
            out_q    <= out_d;
            strobe_q <= strobe_d;
            dout_q   <= dout_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            cap_q    <= cap_d;
            presc_q  <= presc_d;
            slot_q   <= slot_d;
        end
    end
endmodule

// File: tb/tb_grom_io_ctrl.sv
// Self-checking bench for grom_io_ctrl: directed scenarios plus a
// randomized run, all checked against a behavioural model.
module tb_grom_io_ctrl;
    localparam int DW = 8;
    localparam int AW = 12;
    localparam int NP = 4;
    localparam int SD = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NP*DW-1:0]     port_in;
    logic [NP*DW-1:0]     port_out;
    logic [NP-1:0]        out_strobe;
    logic [NP-1:0]        scan_sel;
    logic [DW-1:0]        scan_data;

    int checks   = 0;
    int failures = 0;

    grom_io_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

    grom_io_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_PORTS  (NP),
        .SCAN_DIV   (SD),
        .RESET_VALUE(8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .port_in   (port_in),
        .port_out  (port_out),
        .out_strobe(out_strobe),
        .scan_sel  (scan_sel),
        .scan_data (scan_data)
    );

    always #5 clk = ~clk;

    // Behavioural model
    logic [DW-1:0]    out_m [NP];
    logic [DW-1:0]    cap_m [NP];
    logic [DW-1:0]    dout_m;
    logic [NP-1:0]    strobe_m;
    logic [NP*DW-1:0] hist [$];   // port_in seen at past edges, newest first
    int               n_edges;    // edges since reset release

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int p = 0; p < NP; p++) begin
            out_m[p] = '0;
            cap_m[p] = '0;
        end
        dout_m   = '0;
        strobe_m = '0;
        n_edges  = 0;
        hist.delete();
        repeat (3) hist.push_back('0);
    endfunction

    function automatic void model_edge();
        logic [NP*DW-1:0] sync_in;
        logic [NP*DW-1:0] prv;
        logic [NP*DW-1:0] rise;
        logic [DW-1:0]    clr;
        int               a;
        logic             wr;
        logic             rd;
        sync_in = hist[1];
        prv     = hist[2];
        rise    = sync_in & ~prv;
        wr      = bus_if.ioreq && bus_if.we;
        rd      = bus_if.ioreq && !bus_if.we;
        a       = int'(bus_if.addr);
        strobe_m = '0;
        if (rd) begin
            if (a < NP)
                dout_m = sync_in[a*DW +: DW];
            else if (a < 2*NP)
                dout_m = cap_m[a-NP];
            else
                dout_m = '0;
        end
        for (int p = 0; p < NP; p++) begin
            clr = '0;
            if (wr && a == p) begin
                out_m[p]    = bus_if.data_in;
                strobe_m[p] = 1'b1;
            end
            if (a == NP + p) begin
                if (wr) clr = bus_if.data_in;
                if (rd) clr = '1;
            end
            cap_m[p] = (cap_m[p] & ~clr) | rise[p*DW +: DW];
        end
        hist.push_front(port_in);
        void'(hist.pop_back());
        n_edges++;
    endfunction

    task automatic compare_all();
        logic [NP*DW-1:0] po;
        int               slot;
        for (int p = 0; p < NP; p++) po[p*DW +: DW] = out_m[p];
        slot = (n_edges / SD) % NP;
        check("port_out", port_out, po);
        check("out_strobe", {28'd0, out_strobe}, {28'd0, strobe_m});
        check("data_out", {24'd0, bus_if.data_out}, {24'd0, dout_m});
        check("scan_sel", {28'd0, scan_sel}, 32'd1 << slot);
        check("scan_data", {24'd0, scan_data}, {24'd0, out_m[slot]});
    endtask

    // Inputs are stable here; advance the model, let the edge pass, compare.
    task automatic tick();
        if (reset) model_reset();
        else       model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic bus_op(input logic iq, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus_if.ioreq   = iq;
        bus_if.we      = w;
        bus_if.addr    = a;
        bus_if.data_in = d;
        tick();
        bus_if.ioreq = 1'b0;
        bus_if.we    = 1'b0;
    endtask

    // Asserted mid-cycle with whatever bus cycle is in flight.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("rst_port_out", port_out, 32'd0);
        check("rst_data_out", {24'd0, bus_if.data_out}, 32'd0);
        check("rst_scan_sel", {28'd0, scan_sel}, 32'd1);
        check("rst_strobe", {28'd0, out_strobe}, 32'd0);
        tick();
        tick();
        #2 reset = 1'b0;
        bus_if.ioreq = 1'b0;
        bus_if.we    = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            r;

        reset          = 1'b1;
        port_in        = '0;
        bus_if.addr    = '0;
        bus_if.data_in = '0;
        bus_if.we      = 1'b0;
        bus_if.ioreq   = 1'b0;
        model_reset();
        #7;
        compare_all();
        #5 reset = 1'b0;

        // First scan advance SD cycles after release
        idle(SD - 1);
        check("scan_hold", {28'd0, scan_sel}, 32'd1);
        tick();
        check("scan_adv", {28'd0, scan_sel}, 32'd2);

        // Write with strobe, then an ignored write
        bus_op(1'b1, 1'b1, 12'd2, 8'hA5);
        check("wr_a5", {24'd0, port_out[23:16]}, 32'hA5);
        check("wr_strobe", {28'd0, out_strobe}, 32'h4);
        tick();
        check("strobe_once", {28'd0, out_strobe}, 32'h0);
        bus_op(1'b0, 1'b1, 12'd1, 8'hFF);
        check("noreq_wr", {24'd0, port_out[15:8]}, 32'h00);
        check("noreq_strobe", {28'd0, out_strobe}, 32'h0);

        // Synchronised input read and unmapped read
        port_in[7:0] = 8'h3C;
        idle(3);
        bus_op(1'b1, 1'b0, 12'd0, 8'h00);
        check("rd_sync", {24'd0, bus_if.data_out}, 32'h3C);
        bus_op(1'b1, 1'b0, 12'h100, 8'h00);
        check("rd_unmapped", {24'd0, bus_if.data_out}, 32'h00);

        // Edge capture and read-to-clear
        port_in[9] = 1'b1;
        idle(3);
        bus_op(1'b1, 1'b0, 12'd5, 8'h00);
        check("cap_rd", {24'd0, bus_if.data_out}, 32'h02);
        bus_op(1'b1, 1'b0, 12'd5, 8'h00);
        check("cap_cleared", {24'd0, bus_if.data_out}, 32'h00);

        // Edge coinciding with a clearing read: set wins
        port_in[9] = 1'b0;
        idle(3);
        port_in[9] = 1'b1;
        idle(2);
        bus_op(1'b1, 1'b0, 12'd5, 8'h00);
        bus_op(1'b1, 1'b0, 12'd5, 8'h00);
        check("cap_set_wins", {24'd0, bus_if.data_out}, 32'h02);

        // Write-1-to-clear
        bus_op(1'b1, 1'b0, 12'd4, 8'h00);
        check("cap0_rd", {24'd0, bus_if.data_out}, 32'h3C);
        port_in[7:0] = 8'h81;
        idle(3);
        bus_op(1'b1, 1'b1, 12'd4, 8'h01);
        check("w1c_strobe", {28'd0, out_strobe}, 32'h0);
        check("w1c_port_out", {24'd0, port_out[23:16]}, 32'hA5);
        bus_op(1'b1, 1'b0, 12'd4, 8'h00);
        check("w1c_rd", {24'd0, bus_if.data_out}, 32'h80);

        // Scanner walk over known contents
        do_reset();
        bus_op(1'b1, 1'b1, 12'd0, 8'h11);
        bus_op(1'b1, 1'b1, 12'd1, 8'h22);
        bus_op(1'b1, 1'b1, 12'd2, 8'h33);
        bus_op(1'b1, 1'b1, 12'd3, 8'h44);
        idle(2 * NP * SD);
        a = AW'((n_edges / SD) % NP);
        bus_op(1'b1, 1'b1, a, 8'h5A);
        idle(SD);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 299));
            if (r == 0) begin
                bus_if.ioreq = 1'b1;
                bus_if.we    = 1'($urandom_range(0, 1));
                do_reset();
            end
            if ($urandom_range(0, 3) == 0)
                port_in[$urandom_range(0, NP*DW-1)] ^= 1'b1;
            case ($urandom_range(0, 7))
                6:       a = 12'h100 | AW'($urandom_range(0, 2*NP-1));
                7:       a = AW'($urandom);
                default: a = AW'($urandom_range(0, 2*NP+1));
            endcase
            d = DW'($urandom);
            if ($urandom_range(0, 3) == 0)
                tick();
            else
                bus_op(1'($urandom_range(0, 4) != 0),
                       1'($urandom_range(0, 1)), a, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/grom_io_ctrl.md
Name: grom_io_ctrl

Overview:
Parametrised I/O controller for the grom8 system bus. It replaces the single display latch with NUM_PORTS output registers and NUM_PORTS synchronised input ports with sticky rising-edge capture. It also provides a time-multiplexed scanner that cycles through the output registers for a shared display. It sits beside ram_memory on the CPU bus and responds only to cycles with ioreq=1.

Parameters:
DATA_WIDTH, 8, width of the data bus and of each port.
ADDR_WIDTH, 12, width of the CPU address bus.
NUM_PORTS, 4, number of output registers, input ports and scan slots (1..16).
SCAN_DIV, 1000, clk cycles per scan slot (>=1).
RESET_VALUE, 0, reset value of every output register.

Ports:
clk  in  1  system clock; all state changes on its rising edge.
reset  in  1  asynchronous, active-high reset.
addr  in  ADDR_WIDTH  CPU address; low bits select the I/O register.
data_in  in  DATA_WIDTH  CPU write data.
data_out  out  DATA_WIDTH  registered read data returned to the CPU.
we  in  1  write enable; 1 = write, 0 = read.
ioreq  in  1  I/O cycle qualifier; the block ignores the bus when this is 0.
port_in  in  NUM_PORTS*DATA_WIDTH  asynchronous external inputs; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
port_out  out  NUM_PORTS*DATA_WIDTH  output registers, packed in the same way as port_in.
out_strobe  out  NUM_PORTS  one-cycle pulse when the matching output register is written.
scan_sel  out  NUM_PORTS  one-hot select of the active scan slot.
scan_data  out  DATA_WIDTH  contents of the output register for the active scan slot.

Behaviour:
- Address map (full addr compare; upper bits must be 0):
  - A in 0..NUM_PORTS-1: OUT[A] on write, SYNC_IN[A] on read.
  - A in NUM_PORTS..2*NUM_PORTS-1: CAP[A-NUM_PORTS], the edge-capture register.
  - Any other address: writes ignored, reads return 0.
- Write, when ioreq=1 and we=1:
  - OUT[i] <= data_in at the edge; out_strobe[i]=1 for exactly the following cycle.
  - CAP[i] write is write-1-to-clear: bits set in data_in clear the matching CAP bits.
- Read, when ioreq=1 and we=0: data_out is updated at the edge, giving 1-cycle latency. It holds its value when there is no read.
  - Reading CAP[i] returns its current value and clears it at the same edge.
- Input path:
  - Each port_in bit passes through a 2-FF synchroniser to form SYNC_IN.
  - A previous-value register detects rising edges (SYNC_IN=1, prev=0).
  - A port_in rise before edge 0 becomes visible in SYNC_IN after edge 1 and sets CAP after edge 2.
- CAP set/clear priority: if a rising edge and a clear (read or W1C) hit the same bit in the same cycle, set wins and the bit stays 1.
- Scanner:
  - Prescaler counts 0..SCAN_DIV-1 and wraps. On each wrap, the slot index advances and wraps from NUM_PORTS-1 to 0.
  - scan_sel is the one-hot of the slot index. scan_data = OUT[index], combinational from the registers, so a write shows on scan_data the cycle after the write edge.
  - SCAN_DIV=1 advances the slot every cycle.
  - NUM_PORTS=1 keeps scan_sel=1 permanently.
- ioreq=0: no register reacts to we. Memory cycles never touch I/O state.
- Reset (asynchronous, any time, including mid-scan or with a read pending):
  - port_out = RESET_VALUE for every port; out_strobe=0; data_out=0.
  - CAP=0, synchronisers=0, prev=0.
  - Prescaler=0, slot index=0, scan_sel=1 (slot 0).
  - A read or write in progress at reset is discarded.
- Widths: addr compare is zero-extended; no arithmetic overflow exists except the counter wraps defined above.

Test Plan:
- Reset check: assert reset mid-run -> immediately port_out=0, data_out=0, scan_sel=4'b0001, out_strobe=0; after release, first scan advance occurs SCAN_DIV cycles later.
- Write/strobe: ioreq=1, we=1, addr=2, data_in=8'hA5 -> port_out[23:16]=A5 next cycle, out_strobe=4'b0100 for one cycle only. Repeat with ioreq=0, addr=1 -> port_out[15:8] unchanged, no strobe.
- Input read: port_in[7:0]=8'h3C, wait 3 cycles, read addr=0 -> data_out=3C one cycle after the read edge. Read addr=12'h100 -> data_out=00.
- Edge capture:
  - Raise port_in bit 9 (port 1, bit 1) -> CAP[1]=8'h02 two edges after the synchroniser sees it.
  - Read addr=5 -> returns 02, then a second read returns 00.
  - Re-raise bit 9 so its edge coincides with a read of addr=5 -> CAP[1] remains 02.
- W1C: CAP[0]=8'h81, write addr=4, data_in=8'h01 -> CAP[0]=80, port_out unaffected, no out_strobe.
- Scanner with SCAN_DIV=3, NUM_PORTS=4: OUT = {44,33,22,11} -> scan_sel goes 0001, 0010, 0100, 1000, 0001, each for 3 cycles, with scan_data 11, 22, 33, 44 matching; a write to the active slot changes scan_data on the next cycle.
